vga_line_fetch: RTL and testbench

Prefetch controller feeding pixel data to the VGA timing generator's active area. It consumes the generator's `hdata`/`vdata`/`de` and sequences burst reads from frame memory into an internal FIFO. On each `de` cycle it pops one pixel, so a full frame is streamed in raster order. It restarts at the start of every vertical blanking interval, so the FIFO is prefilled before line 0.

---
 rtl/vga_line_fetch.sv | 150 +++++++++++++++
 tb/tb_vga_line_fetch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetch.sv
// ============================================================================
// vga_line_fetch : burst prefetch of frame-buffer pixels into a FIFO for VGA
// Revision       : 1.0
// ============================================================================
`default_nettype none

module vga_line_fetch #(
  parameter int WIDTH      = 11,
  parameter int HSIZE      = 640,
  parameter int VSIZE      = 480,
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int BASE       = 0,
  parameter int BURST      = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  hdata,
  input  logic [WIDTH-1:0]  vdata,
  input  logic              de,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              req_ready,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              underflow
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CW    = c_PTR_W + 2;
  localparam logic [ADDR_W-1:0] c_TOTAL   = ADDR_W'(HSIZE * VSIZE);
  localparam logic [ADDR_W-1:0] c_BURST_A = ADDR_W'(BURST);
  localparam logic [ADDR_W-1:0] c_BASE    = ADDR_W'(BASE);
  localparam logic [c_CW-1:0]   c_BURST_C = c_CW'(BURST);
  localparam logic [c_CW-1:0]   c_DEPTH_C = c_CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_issued;
  logic [c_CW-1:0]     r_outstanding;
  logic [c_PTR_W:0]    r_count;
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];

  logic                w_fs;
  logic                w_accept;
  logic                w_hold;
  logic                w_fs_arm;
  logic                w_drain_done;
  logic                w_flush;
  logic                w_push;
  logic                w_pop;
  logic                w_issue;
  logic [c_CW-1:0]     w_out_acc;
  logic [c_CW-1:0]     w_out_next;
  logic [c_CW-1:0]     w_need;
  logic [ADDR_W-1:0]   w_iss_acc;
  state_t              w_fs_state;

  assign w_fs       = (vdata == WIDTH'(VSIZE)) && (hdata == '0);
  assign w_accept   = req_valid && req_ready;
  assign w_hold     = req_valid && !req_ready;
  assign w_out_acc  = r_outstanding + (w_accept ? c_BURST_C : '0);
  assign w_out_next = w_out_acc - (rsp_valid ? c_CW'(1) : '0);
  assign w_iss_acc  = r_issued + (w_accept ? c_BURST_A : '0);

  // A burst accepted this cycle already counts against credit.
  assign w_need  = {1'b0, r_count} + w_out_acc + c_BURST_C;
  assign w_issue = (r_state == S_FETCH) && !w_fs && !w_hold &&
                   (w_iss_acc < c_TOTAL) && (w_need <= c_DEPTH_C);

  // A still-pending request is treated as outstanding: its words must be drained.
  assign w_fs_state   = ((w_out_next == '0) && !w_hold) ? S_FETCH : S_DRAIN;
  assign w_fs_arm     = w_fs && (r_state != S_DRAIN);
  assign w_drain_done = (r_state == S_DRAIN) && (r_outstanding == '0) && !req_valid;
  assign w_flush      = w_fs_arm || w_drain_done;
  assign w_push       = rsp_valid && (r_state != S_DRAIN) && !w_flush;
  assign w_pop        = de && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= rsp_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_issued      <= '0;
      r_outstanding <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      req_valid     <= 1'b0;
      req_addr      <= c_BASE;
      pix_data      <= '0;
      underflow     <= 1'b0;
    end else begin
      r_outstanding <= w_out_next;

      if (w_issue) begin
        req_valid <= 1'b1;
        req_addr  <= c_BASE + w_iss_acc;
      end else if (w_accept) begin
        req_valid <= 1'b0;
      end

      if (w_fs_arm)
        r_issued <= '0;
      else if (w_accept && (r_state == S_FETCH))
        r_issued <= w_iss_acc;

      case (r_state)
        S_IDLE, S_DONE: if (w_fs) r_state <= w_fs_state;
        S_FETCH: begin
          if (w_fs)
            r_state <= w_fs_state;
          else if ((r_issued == c_TOTAL) && !req_valid)
            r_state <= S_DONE;
        end
        S_DRAIN: if (w_drain_done) r_state <= S_FETCH;
        default: r_state <= S_IDLE;
      endcase

      if (w_flush) begin
        r_count   <= '0;
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        underflow <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        r_count <= r_count + (c_PTR_W+1)'(w_push) - (c_PTR_W+1)'(w_pop);
        if (de && (r_count == '0)) underflow <= 1'b1;
      end

      if (de) pix_data <= w_pop ? r_mem[r_rd_ptr] : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_line_fetch.sv
// ============================================================================
// tb_vga_line_fetch : randomized bench with a frame-level pixel/request model
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_vga_line_fetch;
  localparam int WIDTH = 11, HSIZE = 8, VSIZE = 2, ADDR_W = 12, DATA_W = 16;
  localparam int BASE = 'h100, BURST = 4, FIFO_DEPTH = 8, HMAX = 12, VMAX = 4;
  localparam int NREQ = HSIZE * VSIZE / BURST;
  localparam int FRAME = HMAX * VMAX;

  logic              clk = 1'b0;
  logic              rst;
  logic [WIDTH-1:0]  hdata, vdata;
  logic              de;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [DATA_W-1:0] pix_data;
  logic              underflow;

  always #5 clk = ~clk;

  vga_line_fetch #(
    .WIDTH(WIDTH), .HSIZE(HSIZE), .VSIZE(VSIZE), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .BASE(BASE), .BURST(BURST), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .hdata(hdata), .vdata(vdata), .de(de),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .pix_data(pix_data), .underflow(underflow)
  );

  typedef struct {int addr; int tag; int due;} word_t;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int h = 0, v = 0;
  int ready_pct = 100, lat_min = 2, lat_max = 2;
  bit rsp_stall = 0;
  word_t rq[$];
  bit cur_v = 0;
  int cur_tag = 0;
  logic [DATA_W-1:0] cur_d;
  logic [DATA_W-1:0] salt;

  // Frame-level reference: words of the current frame in arrival order
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] exp_pix = '0;
  bit exp_uf = 0, armed = 0, req_open = 0;
  int frame = 0, assert_cnt = 0, req_tag = 0, accepts = 0;
  logic [ADDR_W-1:0] exp_addr;
  logic [ADDR_W-1:0] acc_log[$];

  function automatic logic [DATA_W-1:0] mem_word(int a);
    return DATA_W'(a * 40503) ^ salt;
  endfunction

  task automatic drive_inputs();
    hdata = WIDTH'(h);
    vdata = WIDTH'(v);
    de    = (h < HSIZE) && (v < VSIZE);
    if (rq.size() > 0 && !rsp_stall && rq[0].due <= cyc) begin
      cur_v = 1; cur_tag = rq[0].tag; cur_d = mem_word(rq[0].addr);
      void'(rq.pop_front());
    end else begin
      cur_v = 0; cur_d = DATA_W'($urandom);
    end
    rsp_valid = cur_v;
    rsp_data  = cur_d;
    req_ready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic tick();
    bit fs, acc;
    int lat;
    word_t w;
    fs  = (v == VSIZE) && (h == 0);
    acc = req_valid && req_ready;
    n_tests++;
    if (req_open && !req_valid) begin
      n_fail++; $display("FAIL req_withdrawn cyc=%0d: req_valid=%b required 1", cyc, req_valid);
    end
    if (req_valid) begin
      if (!req_open) begin
        req_open = 1; req_tag = frame;
        exp_addr = ADDR_W'(BASE + BURST * assert_cnt);
        assert_cnt++;
        n_tests++;
        if (!armed || assert_cnt > NREQ) begin
          n_fail++;
          $display("FAIL req_issue cyc=%0d: request %0d seen (armed=%0d) required none", cyc, assert_cnt, armed);
        end
      end
      n_tests++;
      if (req_addr !== exp_addr) begin
        n_fail++; $display("FAIL req_addr cyc=%0d: got %h required %h", cyc, req_addr, exp_addr);
      end
    end
    if (acc) begin
      accepts++; acc_log.push_back(req_addr);
      lat = int'($urandom_range(lat_max, lat_min));
      for (int i = 0; i < BURST; i++) begin
        w.addr = int'(req_addr) + i; w.tag = req_tag; w.due = cyc + lat;
        rq.push_back(w);
      end
      req_open = 0;
    end
    if (fs) begin
      mq.delete(); exp_uf = 0; frame++; assert_cnt = 0; armed = 1;
    end else begin
      if (de) begin
        if (mq.size() > 0) exp_pix = mq.pop_front();
        else begin exp_pix = '0; exp_uf = 1; end
      end
      if (cur_v && cur_tag == frame) mq.push_back(cur_d);
    end
    @(posedge clk); #1; cyc++;
    h++;
    if (h == HMAX) begin h = 0; v++; if (v == VMAX) v = 0; end
    n_tests++;
    if (pix_data !== exp_pix) begin
      n_fail++; $display("FAIL pix_data cyc=%0d: got %h required %h", cyc, pix_data, exp_pix);
    end
    n_tests++;
    if (underflow !== exp_uf) begin
      n_fail++; $display("FAIL underflow cyc=%0d: got %b required %b", cyc, underflow, exp_uf);
    end
    n_tests++;
    if (mq.size() > FIFO_DEPTH) begin
      n_fail++; $display("FAIL fifo_fill cyc=%0d: %0d words held, limit %0d", cyc, mq.size(), FIFO_DEPTH);
    end
    drive_inputs();
  endtask

  task automatic run_cycles(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until_fs();
    for (int k = 0; k < 2 * FRAME && !(v == VSIZE && h == 0); k++) tick();
    n_tests++;
    if (!(v == VSIZE && h == 0)) begin
      n_fail++; $display("FAIL fs_timeout: v=%0d h=%0d required v=%0d h=0", v, h, VSIZE);
    end
  endtask

  task automatic wait_req();
    for (int k = 0; k < 20 && !req_valid; k++) tick();
    n_tests++;
    if (req_valid !== 1'b1) begin
      n_fail++; $display("FAIL req_timeout: req_valid=%b required 1", req_valid);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; rsp_valid = 1'b0; cur_v = 0;
    rq.delete(); mq.delete();
    exp_pix = '0; exp_uf = 0; armed = 0; req_open = 0; assert_cnt = 0; frame++;
    @(posedge clk); #1; cyc++;
    n_tests++;
    if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b required 0", req_valid); end
    n_tests++;
    if (req_addr !== ADDR_W'(BASE)) begin n_fail++; $display("FAIL rst_req_addr: got %h required %h", req_addr, ADDR_W'(BASE)); end
    n_tests++;
    if (pix_data !== '0) begin n_fail++; $display("FAIL rst_pix_data: got %h required 0", pix_data); end
    n_tests++;
    if (underflow !== 1'b0) begin n_fail++; $display("FAIL rst_underflow: got %b required 0", underflow); end
    rst = 1'b0;
    drive_inputs();
  endtask

  task automatic test_reset();
    drive_inputs();
    apply_reset();
    run_cycles(4);
  endtask

  task automatic test_nominal();
    ready_pct = 100; lat_min = 2; lat_max = 2;
    run_until_fs();
    acc_log.delete();
    run_cycles(FRAME);
    n_tests++;
    if (acc_log.size() != NREQ) begin
      n_fail++; $display("FAIL nominal_req_count: got %0d required %0d", acc_log.size(), NREQ);
    end
    for (int i = 0; i < acc_log.size() && i < NREQ; i++) begin
      n_tests++;
      if (acc_log[i] !== ADDR_W'(BASE + BURST * i)) begin
        n_fail++; $display("FAIL nominal_addr%0d: got %h required %h", i, acc_log[i], ADDR_W'(BASE + BURST * i));
      end
    end
    n_tests++;
    if (underflow !== 1'b0) begin n_fail++; $display("FAIL nominal_underflow: got %b required 0", underflow); end
  endtask

  task automatic test_ready_stall();
    int a0;
    ready_pct = 0;
    run_until_fs();
    tick();
    wait_req();
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (req_valid !== 1'b1 || req_addr !== ADDR_W'(BASE)) begin
        n_fail++; $display("FAIL stall_hold%0d: valid=%b addr=%h required 1/%h", i, req_valid, req_addr, ADDR_W'(BASE));
      end
      tick();
    end
    a0 = accepts;
    req_ready = 1'b1;
    run_cycles(4);
    n_tests++;
    if (accepts - a0 != 1) begin
      n_fail++; $display("FAIL stall_accepts: got %0d required 1", accepts - a0);
    end
    ready_pct = 100;
    run_until_fs();
  endtask

  task automatic test_rsp_stall();
    ready_pct = 100; lat_min = 2; lat_max = 2;
    run_until_fs();
    rsp_stall = 1;
    tick();
    run_cycles(2 * HMAX + HSIZE);
    n_tests++;
    if (underflow !== 1'b1 || pix_data !== '0) begin
      n_fail++; $display("FAIL starve: underflow=%b pix=%h required 1/0", underflow, pix_data);
    end
    run_until_fs();
    rsp_stall = 0;
    tick();
    n_tests++;
    if (underflow !== 1'b0) begin n_fail++; $display("FAIL starve_clear: got %b required 0", underflow); end
    acc_log.delete();
    run_until_fs();
    n_tests++;
    if (acc_log.size() != NREQ || acc_log[0] !== ADDR_W'(BASE)) begin
      n_fail++; $display("FAIL starve_restart: %0d requests first=%h required %0d/%h", acc_log.size(), acc_log.size() > 0 ? acc_log[0] : '0, NREQ, ADDR_W'(BASE));
    end
  endtask

  task automatic test_random();
    ready_pct = 70; lat_min = 1; lat_max = 5;
    run_cycles(4 * FRAME);
    ready_pct = 100; lat_min = 2; lat_max = 2;
    run_cycles(FRAME);
  endtask

  task automatic test_reset_mid();
    ready_pct = 0;
    run_until_fs();
    tick();
    wait_req();
    apply_reset();
    ready_pct = 100;
    run_until_fs();
    run_cycles(FRAME + 2);
  endtask

  initial begin
    salt = DATA_W'($urandom);
    rst = 1'b1;
    test_reset();
    test_nominal();
    test_ready_stall();
    test_rsp_stall();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
